// File: rtl/lock_seq_ctrl.sv
// Combination-lock sequencer: edge-detected enter strobes step through three
// stored codes, with fail lockout, a timed unlock window and code reprogramming.
module lock_seq_ctrl #(
    parameter logic [4:0] CODE0          = 5'b10000,
    parameter logic [4:0] CODE1          = 5'b01100,
    parameter logic [4:0] CODE2          = 5'b11101,
    parameter int         MAX_FAIL       = 3,
    parameter int         LOCKOUT_CYCLES = 16,
    parameter int         UNLOCK_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] code_in,
    input  logic       enter,
    input  logic       prog,
    output logic       unlocked,
    output logic       lockout,
    output logic [1:0] step,
    output logic [1:0] fail_cnt,
    output logic       prog_active
);

    typedef enum logic [2:0] {IDLE, S1, S2, OPEN, LOCKED, PROG} state_t;

    localparam logic [7:0] UNLOCK_RELOAD = 8'(UNLOCK_CYCLES - 1);
    localparam logic [7:0] LOCK_RELOAD   = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0] MAX_FAIL_V    = 2'(MAX_FAIL);
    localparam logic [2:0] MAX_FAIL_W    = 3'(MAX_FAIL);

    state_t          state_q, state_d;
    logic [2:0][4:0] slot_q, slot_d;
    logic [2:0][4:0] shadow_q, shadow_d;
    logic [1:0]      prog_idx_q, prog_idx_d;
    logic [7:0]      timer_q, timer_d;
    logic [1:0]      fail_d;
    logic [1:0]      step_d;
    logic            enter_q;
    logic            strobe;
    logic [4:0]      cur_code;

    assign strobe = enter & ~enter_q;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        shadow_d   = shadow_q;
        prog_idx_d = prog_idx_q;
        timer_d    = timer_q;
        fail_d     = fail_cnt;
        step_d     = 2'd0;
        cur_code   = slot_q[0];

        case (state_q)
            S1:      cur_code = slot_q[1];
            S2:      cur_code = slot_q[2];
            default: cur_code = slot_q[0];
        endcase

        case (state_q)
            IDLE, S1, S2: begin
                if (strobe) begin
                    if (code_in == cur_code) begin
                        if (state_q == S2) begin
                            state_d = OPEN;
                            fail_d  = 2'd0;
                            timer_d = UNLOCK_RELOAD;
                        end else begin
                            state_d = (state_q == IDLE) ? S1 : S2;
                        end
                    end else if ({1'b0, fail_cnt} + 3'd1 < MAX_FAIL_W) begin
                        state_d = IDLE;
                        fail_d  = fail_cnt + 2'd1;
                    end else begin
                        state_d = LOCKED;
                        timer_d = LOCK_RELOAD;
                        fail_d  = MAX_FAIL_V;
                    end
                end
            end
            OPEN: begin
                timer_d = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;
                // Reprogramming takes priority over the window closing.
                if (prog) begin
                    state_d    = PROG;
                    prog_idx_d = 2'd0;
                end else if (timer_q == 8'd0) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                timer_d = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;
                if (timer_q == 8'd0) begin
                    state_d = IDLE;
                    fail_d  = 2'd0;
                end
            end
            PROG: begin
                // Dropping prog aborts, even when a strobe lands in the same cycle.
                if (!prog) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    case (prog_idx_q)
                        2'd0: begin
                            shadow_d[0] = code_in;
                            prog_idx_d  = 2'd1;
                        end
                        2'd1: begin
                            shadow_d[1] = code_in;
                            prog_idx_d  = 2'd2;
                        end
                        default: begin
                            slot_d     = {code_in, shadow_q[1], shadow_q[0]};
                            prog_idx_d = 2'd0;
                            state_d    = IDLE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            S1:      step_d = 2'd1;
            S2:      step_d = 2'd2;
            OPEN:    step_d = 2'd3;
            default: step_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= {CODE2, CODE1, CODE0};
            shadow_q    <= '0;
            prog_idx_q  <= 2'd0;
            timer_q     <= 8'd0;
            fail_cnt    <= 2'd0;
            enter_q     <= 1'b1;
            unlocked    <= 1'b0;
            lockout     <= 1'b0;
            step        <= 2'd0;
            prog_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            prog_idx_q  <= prog_idx_d;
            timer_q     <= timer_d;
            fail_cnt    <= fail_d;
            enter_q     <= enter;
            unlocked    <= (state_d == OPEN);
            lockout     <= (state_d == LOCKED);
            step        <= step_d;
            prog_active <= (state_d == PROG);
        end
    end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl using default parameters.
module tb_lock_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] code_in;
    logic       enter;
    logic       prog;
    logic       unlocked;
    logic       lockout;
    logic [1:0] step;
    logic [1:0] fail_cnt;
    logic       prog_active;

    int chk_n  = 0;
    int pass_n = 0;

    lock_seq_ctrl dut (
        .clk(clk), .rst(rst), .code_in(code_in), .enter(enter), .prog(prog),
        .unlocked(unlocked), .lockout(lockout), .step(step),
        .fail_cnt(fail_cnt), .prog_active(prog_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One low cycle, then a single-cycle enter pulse; returns just after the strobe edge.
    task automatic press(input logic [4:0] c);
        enter = 1'b0;
        tick();
        code_in = c;
        enter   = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // Counts samples (including the current one) while unlocked stays high.
    task automatic open_len(output int n);
        n = 0;
        while (unlocked && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic lock_len(output int n);
        n = 0;
        while (lockout && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        enter = 1'b0; prog = 1'b0; code_in = 5'd0;
        do_reset();
        chk_n++; if ({unlocked, lockout, step, fail_cnt, prog_active} !== 7'd0)
            $display("FAIL reset_outputs: got %b want 0000000", {unlocked, lockout, step, fail_cnt, prog_active}); else pass_n++;
    endtask

    task automatic test_unlock();
        int n;
        press(5'b10000);
        chk_n++; if (step !== 2'd1) $display("FAIL unlock_step1: got %0d want 1", step); else pass_n++;
        press(5'b01100);
        chk_n++; if (step !== 2'd2) $display("FAIL unlock_step2: got %0d want 2", step); else pass_n++;
        press(5'b11101);
        chk_n++; if (step !== 2'd3 || unlocked !== 1'b1)
            $display("FAIL unlock_open: got step=%0d unlocked=%b want 3/1", step, unlocked); else pass_n++;
        open_len(n);
        chk_n++; if (n !== 8) $display("FAIL unlock_len: got %0d want 8", n); else pass_n++;
        chk_n++; if (step !== 2'd0 || fail_cnt !== 2'd0)
            $display("FAIL unlock_after: got step=%0d fail=%0d want 0/0", step, fail_cnt); else pass_n++;
    endtask

    task automatic test_wrong_third();
        int n;
        press(5'b10000);
        press(5'b01100);
        press(5'b00000);
        chk_n++; if (step !== 2'd0 || fail_cnt !== 2'd1 || unlocked !== 1'b0)
            $display("FAIL wrong3: got step=%0d fail=%0d unl=%b want 0/1/0", step, fail_cnt, unlocked); else pass_n++;
        press(5'b10000);
        press(5'b01100);
        press(5'b11101);
        chk_n++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0)
            $display("FAIL wrong3_retry: got unl=%b fail=%0d want 1/0", unlocked, fail_cnt); else pass_n++;
        open_len(n);
    endtask

    task automatic test_lockout();
        int n;
        press(5'b00001);
        chk_n++; if (fail_cnt !== 2'd1) $display("FAIL lock_fail1: got %0d want 1", fail_cnt); else pass_n++;
        press(5'b00001);
        chk_n++; if (fail_cnt !== 2'd2) $display("FAIL lock_fail2: got %0d want 2", fail_cnt); else pass_n++;
        press(5'b00001);
        chk_n++; if (lockout !== 1'b1 || fail_cnt !== 2'd3)
            $display("FAIL lock_enter: got lock=%b fail=%0d want 1/3", lockout, fail_cnt); else pass_n++;
        // Six edges of ignored strobes (prog raised too) eat six lockout cycles.
        prog = 1'b1;
        press(5'b10000);
        press(5'b01100);
        press(5'b11101);
        prog = 1'b0;
        chk_n++; if (lockout !== 1'b1 || step !== 2'd0 || unlocked !== 1'b0 || prog_active !== 1'b0)
            $display("FAIL lock_ignore: got lock=%b step=%0d unl=%b pa=%b want 1/0/0/0", lockout, step, unlocked, prog_active); else pass_n++;
        lock_len(n);
        chk_n++; if (n !== 10) $display("FAIL lock_len: got %0d want 10 (16 total)", n); else pass_n++;
        chk_n++; if (step !== 2'd0 || fail_cnt !== 2'd0)
            $display("FAIL lock_after: got step=%0d fail=%0d want 0/0", step, fail_cnt); else pass_n++;
    endtask

    task automatic test_held_enter();
        code_in = 5'b10000;
        enter = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        enter = 1'b0;
        tick();
        chk_n++; if (step !== 2'd1) $display("FAIL held_step: got %0d want 1", step); else pass_n++;
        rst = 1'b1;
        enter = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_n++; if (step !== 2'd0) $display("FAIL held_reset: got %0d want 0", step); else pass_n++;
        enter = 1'b0;
        tick();
    endtask

    task automatic test_reprogram();
        int n;
        press(5'b10000);
        press(5'b01100);
        press(5'b11101);
        prog = 1'b1;
        tick();
        chk_n++; if (prog_active !== 1'b1 || unlocked !== 1'b0 || step !== 2'd0)
            $display("FAIL prog_enter: got pa=%b unl=%b step=%0d want 1/0/0", prog_active, unlocked, step); else pass_n++;
        press(5'b00011);
        press(5'b00101);
        chk_n++; if (prog_active !== 1'b1) $display("FAIL prog_mid: got %b want 1", prog_active); else pass_n++;
        press(5'b01001);
        chk_n++; if (prog_active !== 1'b0 || step !== 2'd0)
            $display("FAIL prog_done: got pa=%b step=%0d want 0/0", prog_active, step); else pass_n++;
        prog = 1'b0;
        press(5'b00011);
        press(5'b00101);
        press(5'b01001);
        chk_n++; if (unlocked !== 1'b1) $display("FAIL prog_new_unlock: got %b want 1", unlocked); else pass_n++;
        open_len(n);
        chk_n++; if (n !== 8) $display("FAIL prog_new_len: got %0d want 8", n); else pass_n++;
        press(5'b10000);
        chk_n++; if (step !== 2'd0 || fail_cnt !== 2'd1)
            $display("FAIL prog_old_rejected: got step=%0d fail=%0d want 0/1", step, fail_cnt); else pass_n++;
    endtask

    task automatic test_abort();
        int n;
        press(5'b00011);
        press(5'b00101);
        press(5'b01001);
        prog = 1'b1;
        tick();
        press(5'b11111);
        press(5'b11110);
        prog = 1'b0;
        tick();
        chk_n++; if (prog_active !== 1'b0 || fail_cnt !== 2'd0)
            $display("FAIL abort_exit: got pa=%b fail=%0d want 0/0", prog_active, fail_cnt); else pass_n++;
        press(5'b00011);
        press(5'b00101);
        press(5'b01001);
        chk_n++; if (unlocked !== 1'b1) $display("FAIL abort_codes_kept: got %b want 1", unlocked); else pass_n++;
        open_len(n);
    endtask

    task automatic test_reset_lockout();
        int n;
        press(5'b00001);
        press(5'b00001);
        press(5'b00001);
        tick();
        tick();
        chk_n++; if (lockout !== 1'b1) $display("FAIL rstlock_pre: got %b want 1", lockout); else pass_n++;
        rst = 1'b1;
        tick();
        chk_n++; if (lockout !== 1'b0 || fail_cnt !== 2'd0 || step !== 2'd0)
            $display("FAIL rstlock_clear: got lock=%b fail=%0d step=%0d want 0/0/0", lockout, fail_cnt, step); else pass_n++;
        rst = 1'b0;
        press(5'b10000);
        press(5'b01100);
        press(5'b11101);
        chk_n++; if (unlocked !== 1'b1) $display("FAIL rstlock_defaults: got %b want 1", unlocked); else pass_n++;
        open_len(n);
        chk_n++; if (n !== 8) $display("FAIL rstlock_len: got %0d want 8", n); else pass_n++;
    endtask

    initial begin
        rst = 1'b1; enter = 1'b0; prog = 1'b0; code_in = 5'd0;
        test_reset();
        test_unlock();
        test_wrong_third();
        test_lockout();
        test_held_enter();
        test_reprogram();
        test_abort();
        do_reset();
        test_reset_lockout();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
